// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame geometry and the
// odd-parity helper used by both the receiver and the transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_DONE = 2'd2
    } rx_state_t;

    localparam int FRAME_DATA_BITS = 8;
    // Parity bit plus stop bit.
    localparam int FRAME_TAIL_BITS = 2;

    // Parity bit that makes {data, parity} contain an odd number of ones.
    function automatic logic odd_parity(input logic [FRAME_DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the asynchronous PS/2 clock pin and emits a one-cycle pulse on
// each clean falling edge of the filtered level.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic ps2c_i,
    output logic fall_o
);

    logic [FILTER_LEN-1:0] shreg;
    logic                  filt_q;
    logic                  filt_d;

    // The filtered level only moves once FILTER_LEN samples agree.
    always_comb begin
        filt_d = filt_q;
        if (&shreg) begin
            filt_d = 1'b1;
        end else if (~|shreg) begin
            filt_d = 1'b0;
        end
    end

    // Sample history and filtered level; the idle bus level is high.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shreg  <= '1;
            filt_q <= 1'b1;
        end else begin
            shreg  <= {shreg[FILTER_LEN-2:0], ps2c_i};
            filt_q <= filt_d;
        end
    end

    assign fall_o = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Data is sampled on filtered falling edges of ps2c.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       rx_en_i,
    input  logic       ps2d_i,
    input  logic       ps2c_i,
    output logic [7:0] rx_data_o,
    output logic       rx_done_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       idle_o
);

    localparam int              FRAME_BITS = FRAME_DATA_BITS + FRAME_TAIL_BITS;
    localparam int              TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    // Falls remaining after the start bit: data, parity, then stop at zero.
    localparam logic [3:0]      CNT_LOAD   = 4'(FRAME_BITS - 1);

    rx_state_t                  state_q, state_d;
    logic [3:0]                 bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]      shift_q, shift_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [7:0]                 data_q, data_d;
    logic                       done_q, done_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic [1:0]                 d_sync;
    logic                       fall;
    logic                       ps2d;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .ps2c_i  (ps2c_i),
        .fall_o  (fall)
    );

    // Two-flop synchronizer for the data pin; idles high.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            d_sync <= 2'b11;
        end else begin
            d_sync <= {d_sync[0], ps2d_i};
        end
    end

    assign ps2d = d_sync[1];

    // Next-state and strobe logic. Result data and flags are registered on
    // the stop-bit fall so rx_data_o is already valid while rx_done_o is high.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        done_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (!rx_en_i) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (fall && !ps2d) begin
                        bit_cnt_d = CNT_LOAD;
                        tmo_d     = '0;
                        state_d   = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (fall) begin
                        shift_d = {ps2d, shift_q[FRAME_BITS-1:1]};
                        tmo_d   = '0;
                        if (bit_cnt_q == 4'd0) begin
                            state_d = RX_DONE;
                            done_d  = 1'b1;
                            data_d  = shift_d[7:0];
                            perr_d  = (odd_parity(shift_d[7:0]) != shift_d[8]);
                            ferr_d  = ~shift_d[9];
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Device stopped clocking mid-frame: abandon it.
                        ferr_d  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                RX_DONE: begin
                    state_d = RX_IDLE;
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered strobes.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_done_o    = done_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign idle_o       = (state_q == RX_IDLE);

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 host-side receiver for device-to-host frames (keyboard/mouse to FPGA).
- Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1).
- Samples data on filtered falling edges of the device-driven PS/2 clock.
- Delivers the byte with a one-cycle done strobe and error flags; the top level shares the ps2d/ps2c pins with ps2_tx and deasserts rx_en_i while ps2_tx is not idle.

Parameters:
- FILTER_LEN, 8: number of consecutive identical ps2c samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 20000: clk_i cycles allowed between consecutive falling edges inside a frame (200 us at 100 MHz).

Ports:
- clk_i  input  1  system clock.
- reset_ni  input  1  asynchronous active-low reset.
- rx_en_i  input  1  receive enable; low forces the block to IDLE.
- ps2d_i  input  1  PS/2 data line (pin value; asynchronous).
- ps2c_i  input  1  PS/2 clock line (pin value; asynchronous).
- rx_data_o  output  8  last received data byte.
- rx_done_o  output  1  one-cycle strobe when a frame completes.
- parity_err_o  output  1  valid with rx_done_o; 1 means the odd-parity check failed.
- frame_err_o  output  1  one-cycle strobe: bad stop bit (together with rx_done_o) or inter-edge timeout (alone).
- idle_o  output  1  high when state is IDLE.

Behaviour:
- Clock and reset:
  - Single clock domain. One clock, reset is asynchronous and active-low.
  - On reset: state IDLE; filter shift register all ones; filtered clock 1; ps2d synchronizer 1; shift register 0; bit count 0; timeout count 0.
  - Output reset values: rx_data_o = 0x00, rx_done_o = 0, parity_err_o = 0, frame_err_o = 0, idle_o = 1.
- Input conditioning:
  - ps2d_i passes through a 2-flop synchronizer.
  - ps2c_i shifts into a FILTER_LEN-bit register.
  - The filtered clock becomes 1 when the register is all ones, 0 when it is all zeros, and holds otherwise.
  - fall = filtered_reg & ~filtered_next. This is asserted for exactly one cycle per clean falling edge.
- FSM states: IDLE, DATA, DONE.
- IDLE:
  - If rx_en_i, fall, and synced ps2d == 0: load bit count = 9, clear the timeout counter, go to DATA.
  - fall with ps2d == 1 is ignored (not a start bit).
- DATA:
  - On fall: shift synced ps2d into bit 9 of a 10-bit shift register (right shift) and clear the timeout counter.
  - If bit count == 0 on that fall, go to DONE (the stop bit has just been captured). Otherwise decrement bit count.
  - With no fall, the timeout counter increments. When it reaches TIMEOUT_CYCLES-1: pulse frame_err_o next cycle and go to IDLE; rx_done_o stays 0 and rx_data_o is unchanged.
- DONE (exactly one cycle):
  - rx_data_o <= shift[7:0].
  - rx_done_o = 1.
  - parity_err_o = ~(^shift[8:0]).
  - frame_err_o = ~shift[9].
  - Next state IDLE.
  - Latency: rx_done_o is high the cycle after the cycle in which the stop-bit fall is detected.
- rx_en_i low in any state: next state IDLE, no strobes, partial frame discarded. rx_data_o keeps its last value.
- All strobes are registered and high for exactly one cycle. parity_err_o is 0 whenever rx_done_o is 0.
- Reset mid-frame returns to the reset state immediately. The remainder of the interrupted frame is ignored until a new start edge arrives.
- Glitches on ps2c shorter than FILTER_LEN cycles produce no fall.
- The data line is never driven; the block is input-only.

Decomposition:
- ps2_pkg:
  - ps2_rx state enum (IDLE, DATA, DONE).
  - Constants FRAME_DATA_BITS = 8 and FRAME_TAIL_BITS = 2 (parity + stop).
  - Odd-parity function, shared with ps2_tx.
- Sub-module ps2_clk_filter: FILTER_LEN filter plus falling-edge pulse. It is reusable by ps2_tx to replace its inline filter.

Test Plan:
1. Valid frame 0x1C: data bits 0,0,1,1,1,0,0,0; parity 0; stop 1; 40 us clock period. Expect rx_data_o = 0x1C, one rx_done_o pulse, parity_err_o = 0, frame_err_o = 0, idle_o = 1 afterward.
2. Frame 0x00 sent with parity 0 (correct is 1). Expect rx_done_o = 1, parity_err_o = 1, rx_data_o = 0x00, frame_err_o = 0.
3. Frame 0xF0 with stop bit 0. Expect rx_done_o = 1, frame_err_o = 1 in the same cycle, rx_data_o = 0xF0.
4. Clock stops after 5 bits of a frame for more than TIMEOUT_CYCLES. Expect a single frame_err_o pulse, no rx_done_o, idle_o = 1. A following valid 0xAA frame is received correctly.
5. Inject 3-cycle low glitches on ps2c throughout frame 0x5A. Expect rx_data_o = 0x5A and no extra or missing bits.
6. Drop rx_en_i after bit 4, and separately assert reset_ni = 0 after bit 6. Expect no strobes, immediate IDLE, and the next full frame 0x12 received correctly.
